// File: rtl/param_computational_unit.sv
// Parametrised nibble-processor computational unit: shared data bus, register file, flag ALU and multi-cycle shift-add multiplier.
// Optional macro SATURATE_EN makes subtract, add and add-with-carry clamp instead of wrapping.
module param_computational_unit #(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        source_sel,
    input  logic [8:0]        reg_en,
    input  logic              i_sel,
    input  logic              x_sel,
    input  logic              y_sel,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] dm,
    input  logic [DATA_W-1:0] i_pins,
    output logic [DATA_W-1:0] data_bus,
    output logic [DATA_W-1:0] o_reg,
    output logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] m,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] r,
    output logic [DATA_W-1:0] r_hi,
    output logic              r_eq_0,
    output logic              c_flag,
    output logic              busy,
    output logic              mul_done
);

    typedef enum logic [3:0] {
        OP_NEG = 4'd0, OP_SUB = 4'd1, OP_ADD = 4'd2, OP_MUL = 4'd3,
        OP_XOR = 4'd4, OP_AND = 4'd5, OP_NOT = 4'd6, OP_OR  = 4'd7,
        OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ADC = 4'd10
    } alu_op_e;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0]   xo, yo, alu_res, mcand;
    logic [DATA_W:0]     wide, step_sum;
    logic                alu_c, alu_wr;
    logic [2*DATA_W-1:0] acc, acc_next;
    logic [CNT_W-1:0]    cnt;
    logic                unused_reg_en7;

    assign unused_reg_en7 = reg_en[7];
    assign xo = x_sel ? x1 : x0;
    assign yo = y_sel ? y1 : y0;

    always_comb begin
        case (source_sel)
            4'd0:    data_bus = x0;
            4'd1:    data_bus = x1;
            4'd2:    data_bus = y0;
            4'd3:    data_bus = y1;
            4'd4:    data_bus = r;
            4'd5:    data_bus = m;
            4'd6:    data_bus = i;
            4'd7:    data_bus = dm;
            4'd8:    data_bus = imm;
            4'd9:    data_bus = i_pins;
            4'd10:   data_bus = r_hi;
            default: data_bus = '0;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        wide    = '0;
        case (alu_op)
            OP_NEG: begin
                wide    = {1'b0, {DATA_W{1'b0}}} - {1'b0, xo};
                alu_res = wide[DATA_W-1:0];
                alu_c   = |xo;
            end
            OP_SUB: begin
                wide    = {1'b0, xo} - {1'b0, yo};
                alu_c   = wide[DATA_W];
`ifdef SATURATE_EN
                alu_res = wide[DATA_W] ? '0 : wide[DATA_W-1:0];
`else
                alu_res = wide[DATA_W-1:0];
`endif
            end
            OP_ADD, OP_ADC: begin
                wide = {1'b0, xo} + {1'b0, yo}
                     + ((alu_op == OP_ADC) ? {{DATA_W{1'b0}}, c_flag} : '0);
                alu_c = wide[DATA_W];
`ifdef SATURATE_EN
                alu_res = wide[DATA_W] ? '1 : wide[DATA_W-1:0];
`else
                alu_res = wide[DATA_W-1:0];
`endif
            end
            OP_XOR: alu_res = xo ^ yo;
            OP_AND: alu_res = xo & yo;
            OP_NOT: alu_res = ~xo;
            OP_OR:  alu_res = xo | yo;
            OP_SHL: begin
                alu_res = {xo[DATA_W-2:0], 1'b0};
                alu_c   = xo[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, xo[DATA_W-1:1]};
                alu_c   = xo[0];
            end
            default: alu_wr = 1'b0;  // multiply start and codes 11-15 leave r and flags alone
        endcase
    end

    // Upper half accumulates the multiplicand, lower half shifts out multiplier bits LSB first.
    assign step_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_next = {step_sum, acc[DATA_W-1:1]};

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0 <= '0; x1 <= '0; y0 <= '0; y1 <= '0;
            m  <= '0; i  <= '0; o_reg <= '0;
            r  <= '0; r_hi <= '0;
            r_eq_0   <= 1'b1;
            c_flag   <= 1'b0;
            busy     <= 1'b0;
            mul_done <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            mul_done <= 1'b0;
            if (reg_en[0]) x0    <= data_bus;
            if (reg_en[1]) x1    <= data_bus;
            if (reg_en[2]) y0    <= data_bus;
            if (reg_en[3]) y1    <= data_bus;
            if (reg_en[5]) m     <= data_bus;
            if (reg_en[6]) i     <= i_sel ? i + m : data_bus;
            if (reg_en[8]) o_reg <= data_bus;

            if (busy) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (cnt == LAST_STEP) begin
                    r        <= acc_next[DATA_W-1:0];
                    r_hi     <= acc_next[2*DATA_W-1:DATA_W];
                    r_eq_0   <= (acc_next == '0);
                    c_flag   <= 1'b0;
                    busy     <= 1'b0;
                    mul_done <= 1'b1;
                end
            end else if (reg_en[4]) begin
                if (alu_op == OP_MUL) begin
                    mcand <= xo;
                    acc   <= {{DATA_W{1'b0}}, yo};
                    cnt   <= '0;
                    busy  <= 1'b1;
                end else if (alu_wr) begin
                    r      <= alu_res;
                    r_eq_0 <= (alu_res == '0);
                    c_flag <= alu_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_computational_unit.sv
// Self-checking bench for param_computational_unit (DATA_W=8): table-driven ALU vectors plus multiply, index and reset sequences.
module tb_param_computational_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   source_sel;
    logic [8:0]   reg_en;
    logic         i_sel, x_sel, y_sel;
    logic [3:0]   alu_op;
    logic [W-1:0] imm, dm, i_pins;
    logic [W-1:0] data_bus, o_reg, i, m, x0, x1, y0, y1, r, r_hi;
    logic         r_eq_0, c_flag, busy, mul_done;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [3:0]   op;
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } vec_t;

    vec_t             tbl[12];
    vec_t             sb[$];
    logic [2*W-1:0]   mul_sb[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    always #5 clk = ~clk;

    param_computational_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .source_sel(source_sel), .reg_en(reg_en),
        .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel), .alu_op(alu_op),
        .imm(imm), .dm(dm), .i_pins(i_pins), .data_bus(data_bus),
        .o_reg(o_reg), .i(i), .m(m), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .r(r), .r_hi(r_hi), .r_eq_0(r_eq_0), .c_flag(c_flag),
        .busy(busy), .mul_done(mul_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        source_sel = 4'd0;
        reg_en     = '0;
        i_sel      = 1'b0;
        alu_op     = 4'd0;
        imm        = '0;
    endtask

    task automatic load(input int en_bit, input logic [W-1:0] v);
        idle();
        source_sel     = 4'd8;
        imm            = v;
        reg_en[en_bit] = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        vec_t         e;
        vec_t         last;
        logic [2*W-1:0] pexp;
        logic [W-1:0] mx, my;
        int           cyc;
        logic         saw_done;

`ifdef SATURATE_EN
        tbl[0]  = '{8'hF0, 8'h20, 4'd2,  8'hFF, 1'b1, 1'b0};
        tbl[1]  = '{8'h05, 8'h07, 4'd1,  8'h00, 1'b1, 1'b1};
        tbl[11] = '{8'hFF, 8'h01, 4'd2,  8'hFF, 1'b1, 1'b0};
`else
        tbl[0]  = '{8'hF0, 8'h20, 4'd2,  8'h10, 1'b1, 1'b0};
        tbl[1]  = '{8'h05, 8'h07, 4'd1,  8'hFE, 1'b1, 1'b0};
        tbl[11] = '{8'hFF, 8'h01, 4'd2,  8'h00, 1'b1, 1'b1};
`endif
        tbl[2]  = '{8'h00, 8'h00, 4'd0,  8'h00, 1'b0, 1'b1};
        tbl[3]  = '{8'h12, 8'h00, 4'd0,  8'hEE, 1'b1, 1'b0};
        tbl[4]  = '{8'h3C, 8'h0F, 4'd4,  8'h33, 1'b0, 1'b0};
        tbl[5]  = '{8'h3C, 8'h0F, 4'd5,  8'h0C, 1'b0, 1'b0};
        tbl[6]  = '{8'h3C, 8'h0F, 4'd6,  8'hC3, 1'b0, 1'b0};
        tbl[7]  = '{8'h3C, 8'h0F, 4'd7,  8'h3F, 1'b0, 1'b0};
        tbl[8]  = '{8'h81, 8'h00, 4'd8,  8'h02, 1'b1, 1'b0};
        tbl[9]  = '{8'h10, 8'h20, 4'd10, 8'h31, 1'b0, 1'b0};
        tbl[10] = '{8'h81, 8'h00, 4'd9,  8'h40, 1'b1, 1'b0};

        reset = 1'b1; x_sel = 1'b0; y_sel = 1'b0;
        dm = '0; i_pins = '0;
        idle();
        #1;
        check("reset_r",      r,        0);
        check("reset_r_hi",   r_hi,     0);
        check("reset_r_eq_0", r_eq_0,   1);
        check("reset_c_flag", c_flag,   0);
        check("reset_busy",   busy,     0);
        check("reset_done",   mul_done, 0);
        tick();
        reset = 1'b0;
        tick();

        // ALU vectors through x0/y0
        for (int k = 0; k < 12; k++) begin
            load(0, tbl[k].x);
            load(2, tbl[k].y);
            alu_op    = tbl[k].op;
            reg_en[4] = 1'b1;
            sb.push_back(tbl[k]);
            tick();
            idle();
            e = sb.pop_front();
            check($sformatf("alu%0d_r", k), r,      e.r);
            check($sformatf("alu%0d_c", k), c_flag, e.c);
            check($sformatf("alu%0d_z", k), r_eq_0, e.z);
            last = e;
        end

        alu_op = 4'd12; reg_en[4] = 1'b1;
        tick();
        idle();
        check("nop_r", r,      last.r);
        check("nop_c", c_flag, last.c);
        check("nop_z", r_eq_0, last.z);

        source_sel = 4'd7; dm = 8'h5A; reg_en[8] = 1'b1;
        tick();
        idle();
        check("o_reg_from_dm", o_reg, 8'h5A);

        // Multiply 0xFF*0xFF with a mid-run operand change and a second start
        mx = 8'hFF; my = 8'hFF;
        load(1, mx);
        load(3, my);
        x_sel = 1'b1; y_sel = 1'b1;
        alu_op = 4'd3; reg_en[4] = 1'b1;
        mul_sb.push_back({8'h00, mx} * {8'h00, my});
        tick();
        idle();
        check("mul_busy_T", busy, 1);
        cyc = 0;
        saw_done = 1'b0;
        while (!saw_done && cyc < 20) begin
            cyc++;
            if (cyc == 2) begin
                source_sel = 4'd8; imm = 8'h00; reg_en[1] = 1'b1;
            end
            if (cyc == 3) begin
                alu_op = 4'd2; reg_en[4] = 1'b1;
            end
            tick();
            idle();
            if (mul_done) begin
                saw_done = 1'b1;
            end else begin
                check($sformatf("mul_busy_T%0d", cyc), busy, 1);
                check($sformatf("mul_r_frozen_T%0d", cyc), r, last.r);
            end
        end
        check("mul_latency", cyc, W);
        check("mul_busy_end", busy, 0);
        pexp = mul_sb.pop_front();
        check("mul_r",    r,      pexp[W-1:0]);
        check("mul_r_hi", r_hi,   pexp[2*W-1:W]);
        check("mul_z",    r_eq_0, (pexp == '0));
        check("mul_c",    c_flag, 0);
        check("x1_loaded_during_mul", x1, 8'h00);
        tick();
        check("mul_done_pulse", mul_done, 0);

        // Index register arithmetic with wrap
        load(5, 8'h03);
        load(6, 8'hFE);
        i_sel = 1'b1; reg_en[6] = 1'b1;
        tick();
        check("i_inc1", i, 8'h01);
        tick();
        check("i_inc2", i, 8'h04);
        idle();
        source_sel = 4'd10;
        #1;
        check("bus_r_hi", data_bus, pexp[2*W-1:W]);
        source_sel = 4'd4;
        #1;
        check("bus_r", data_bus, pexp[W-1:0]);
        source_sel = 4'd13;
        #1;
        check("bus_sel13", data_bus, 0);
        idle();
        tick();

        // Reset during a multiply aborts it
        load(1, 8'h12);
        load(3, 8'h34);
        alu_op = 4'd3; reg_en[4] = 1'b1;
        tick();
        idle();
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("abort_busy",   busy,   0);
        check("abort_r",      r,      0);
        check("abort_r_hi",   r_hi,   0);
        check("abort_r_eq_0", r_eq_0, 1);
        #1;
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (mul_done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_r_after", r, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/param_computational_unit.md
Name: param_computational_unit

Overview:
- Next-generation computational unit for the nibble-processor family.
- Datapath width is parametrised.
- ALU op field widened to 4 bits; adds carry flag, logic/shift ops and a multi-cycle shift-add multiplier returning the full double-width product (r = low half, r_hi = high half).
- Sits between the instruction decoder (source_sel, reg_en, selects, op field) and data memory / I/O pins; shared data_bus feeds all loadable registers.

Parameters:
- DATA_W, 8, width of data_bus, every data register, ALU operands and result.
- CNT_W, $clog2(DATA_W)+1, width of the multiplier iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- source_sel  in  4  data_bus source select.
- reg_en  in  9  load enables: [0]x0 [1]x1 [2]y0 [3]y1 [4]ALU execute [5]m [6]i [7]unused [8]o_reg.
- i_sel  in  1  0: i loads data_bus; 1: i <= i + m (wraps mod 2^DATA_W).
- x_sel, y_sel  in  1 each  ALU operand select: 0 → x0/y0, 1 → x1/y1.
- alu_op  in  4  ALU function code.
- imm  in  DATA_W  immediate from program memory.
- dm  in  DATA_W  data memory read value.
- i_pins  in  DATA_W  input pins.
- data_bus  out  DATA_W  current bus value (combinational).
- o_reg, i, m, x0, x1, y0, y1, r, r_hi  out  DATA_W each  register contents.
- r_eq_0  out  1  zero flag.
- c_flag  out  1  carry/borrow flag.
- busy  out  1  multiplier in progress.
- mul_done  out  1  one-cycle pulse when product written.

Behaviour:
- Reset: all registers = 0, r_eq_0 = 1, c_flag = 0, busy = 0, mul_done = 0, counter = 0. Reset asserted mid-multiply aborts it; r/r_hi are not written afterward.
- data_bus mux: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 imm, 9 i_pins, 10 r_hi, 11-15 → 0.
- Register loads: one cycle, independent, all legal while busy. Multiplier uses operands latched at start.
- Single-cycle ops (reg_en[4]=1, busy=0): r <= result at the edge; r_eq_0 <= (result==0). Codes:
  - 0 -x: c = (x!=0).
  - 1 x-y: c = borrow (x<y).
  - 2 x+y: c = carry out.
  - 4 x^y, 5 x&y, 6 ~x, 7 x|y: c <= 0.
  - 8 x<<1: c = x[MSB].
  - 9 x>>1 (logical): c = x[0].
  - 10 x+y+c: c = carry out.
  - 11-15: NOP; r, r_eq_0, c_flag unchanged.
- Multiply (op 3; reg_en[4]=1, busy=0 at edge T):
  - Latch x, y; clear accumulator; busy = 1 from edge T.
  - One shift-add step per cycle, DATA_W steps.
  - At edge T+DATA_W: r <= product[DATA_W-1:0], r_hi <= product[2*DATA_W-1:DATA_W], r_eq_0 <= (full product==0), c_flag <= 0, busy <= 0, mul_done = 1 for that cycle only.
- reg_en[4] while busy: ignored entirely; no queueing. Flags and r are frozen during multiply.
- Register written by loads and by the ALU: no conflict, since loads cannot target r/r_hi.
- Arithmetic unsigned, modulo 2^DATA_W (unless SATURATE_EN). The i increment wraps.

Optional Feature:
- Macro SATURATE_EN.
- Defined: ops 1, 2, 10 saturate; overflow clamps r to all-ones, borrow clamps r to 0. c_flag still reports the raw carry/borrow. r_eq_0 is computed on the clamped value.
- Undefined: wrap-around arithmetic as above.

Test Plan (DATA_W=8):
- Reset low: load x0=0xF0 via imm (src 8, reg_en[0]); y0=0x20; op 2 → r=0x10, c_flag=1, r_eq_0=0. With SATURATE_EN: r=0xFF, c_flag=1.
- x0=0x05, y0=0x07, op 1 → r=0xFE, c_flag=1. Then op 0 with x0=0 → r=0x00, r_eq_0=1, c_flag=0.
- x1=0xFF, y1=0xFF, x_sel=y_sel=1, op 3 at edge T:
  - busy high T..T+7.
  - mul_done at T+8; r=0x01, r_hi=0xFE, r_eq_0=0.
  - Second reg_en[4] at T+3 ignored.
  - Changing x1 at T+2 does not alter the product.
- m=0x03, i=0xFE, i_sel=1, reg_en[6] two cycles → i=0x01, then 0x04. source_sel 10 → data_bus = r_hi; source_sel 13 → 0.
- Start multiply, assert reset at T+4 → busy=0, r=0, r_hi=0, r_eq_0=1 immediately (no clock). No mul_done afterward.
- op 9 on x0=0x81 → r=0x40, c_flag=1. Then op 12 (NOP) → r, c_flag, r_eq_0 unchanged.
